vend_ctrl_gen: RTL

Parametrised vending-transaction controller: N-item catalogue with per-item price and stock, quantity selection, coin acceptance with overflow/reject handling, inactivity timeout refund, and serial coin-by-coin change dispensing. Sits between the coin/keypad front end (debounced, one-cycle pulses) and the display/LED drivers. It replaces a fixed-catalogue design that computed change as a single value and had no inventory or timeout.

---
 rtl/vend_ctrl_gen.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/vend_ctrl_gen.sv
// Vending transaction controller: item/quantity selection with stock tracking,
// coin collection with overflow reject, inactivity refund and greedy coin-by-coin change.
module vend_ctrl_gen #(
  parameter int N_ITEMS = 5,
  parameter int CENT_W = 12,
  parameter logic [N_ITEMS*CENT_W-1:0] PRICE_VEC = {12'd150, 12'd120, 12'd100, 12'd80, 12'd50},
  parameter int MAX_QTY = 3,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 9,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_ITEMS-1:0]  item_sel,
  input  logic [1:0]          qty_sel,
  input  logic                coin_vld,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                cont,
  input  logic                restock,
  output logic [2:0]          state_o,
  output logic [3:0]          item_idx,
  output logic [1:0]          qty,
  output logic [CENT_W-1:0]   collected,
  output logic [CENT_W-1:0]   change_rem,
  output logic                vend_pulse,
  output logic                coin_out_vld,
  output logic [1:0]          coin_out_type,
  output logic                coin_reject,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                timeout_evt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VEND    = 3'd2,
    S_CHANGE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t               state;
  logic [STOCK_W-1:0]   stock [N_ITEMS];
  logic [TW-1:0]        idle_cnt;
  logic                 refund;

  logic [1:0]           q_eff;
  logic [3:0]           sel_idx;
  logic [STOCK_W-1:0]   sel_stock;
  logic                 sel_valid;
  logic [CENT_W-1:0]    cur_price;
  logic [CENT_W-1:0]    cost;
  logic [CENT_W:0]      coin_sum;
  logic                 coin_ok;
  logic [CENT_W-1:0]    coll_next;
  logic [CENT_W-1:0]    vend_change;
  logic [CENT_W-1:0]    rem_next;
  logic                 timeout_hit;
  logic                 abort;

  function automatic logic [CENT_W-1:0] coin_value(input logic [1:0] t);
    case (t)
      2'd0:    return CENT_W'(5);
      2'd1:    return CENT_W'(10);
      2'd2:    return CENT_W'(25);
      default: return CENT_W'(100);
    endcase
  endfunction

  function automatic logic [1:0] greedy_pick(input logic [CENT_W-1:0] rem);
    if (rem >= CENT_W'(100))     return 2'd3;
    else if (rem >= CENT_W'(25)) return 2'd2;
    else if (rem >= CENT_W'(10)) return 2'd1;
    else                         return 2'd0;
  endfunction

  assign state_o = state;

  always_comb begin
    q_eff = qty_sel;
    if (qty_sel == 2'd0)
      q_eff = 2'd1;
    else if (int'(qty_sel) > MAX_QTY)
      q_eff = 2'(MAX_QTY);
  end

  always_comb begin
    sel_idx   = '0;
    sel_stock = '0;
    cur_price = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (item_sel[i]) begin
        sel_idx   = 4'(i);
        sel_stock = stock[i];
      end
      if (item_idx == 4'(i))
        cur_price = PRICE_VEC[i*CENT_W +: CENT_W];
    end
  end

  assign sel_valid   = $onehot(item_sel) && (sel_stock >= STOCK_W'(q_eff));
  assign cost        = cur_price * CENT_W'(qty);
  assign coin_sum    = {1'b0, collected} + {1'b0, coin_value(coin_type)};
  assign coin_ok     = coin_vld && !coin_sum[CENT_W];
  assign coll_next   = coin_ok ? coin_sum[CENT_W-1:0] : collected;
  assign vend_change = collected - cost;
  assign rem_next    = change_rem - coin_value(coin_out_type);
  assign timeout_hit = (state == S_COLLECT) && !coin_vld && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign abort       = cancel || timeout_hit;

  // coin_out_type always holds the coin for the current CHANGE cycle,
  // so every transition into or within CHANGE precomputes the next coin.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      item_idx      <= '0;
      qty           <= 2'd1;
      collected     <= '0;
      change_rem    <= '0;
      vend_pulse    <= 1'b0;
      coin_out_vld  <= 1'b0;
      coin_out_type <= '0;
      coin_reject   <= 1'b0;
      timeout_evt   <= 1'b0;
      idle_cnt      <= '0;
      refund        <= 1'b0;
      sold_out      <= '0;
      for (int i = 0; i < N_ITEMS; i++)
        stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      vend_pulse  <= 1'b0;
      timeout_evt <= 1'b0;
      coin_reject <= coin_vld && ((state != S_COLLECT) || coin_sum[CENT_W]);

      case (state)
        S_IDLE: begin
          collected  <= '0;
          change_rem <= '0;
          refund     <= 1'b0;
          if (restock) begin
            for (int i = 0; i < N_ITEMS; i++) begin
              stock[i]    <= STOCK_W'(INIT_STOCK);
              sold_out[i] <= (INIT_STOCK == 0);
            end
          end
          if (sel_valid) begin
            item_idx <= sel_idx;
            qty      <= q_eff;
            idle_cnt <= '0;
            state    <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          collected <= coll_next;
          if (coin_vld)
            idle_cnt <= '0;
          else
            idle_cnt <= idle_cnt + 1'b1;
          // A cancel (or timeout) wins over payment; a same-cycle coin joins the refund.
          if (abort) begin
            timeout_evt <= timeout_hit;
            if (coll_next != '0) begin
              state         <= S_CHANGE;
              change_rem    <= coll_next;
              refund        <= 1'b1;
              coin_out_vld  <= 1'b1;
              coin_out_type <= greedy_pick(coll_next);
            end else begin
              state     <= S_IDLE;
              collected <= '0;
            end
          end else if (collected >= cost) begin
            state      <= S_VEND;
            vend_pulse <= 1'b1;
          end
        end

        S_VEND: begin
          for (int i = 0; i < N_ITEMS; i++) begin
            if (item_idx == 4'(i)) begin
              stock[i]    <= stock[i] - STOCK_W'(qty);
              sold_out[i] <= ((stock[i] - STOCK_W'(qty)) == '0);
            end
          end
          change_rem <= vend_change;
          if (vend_change != '0) begin
            state         <= S_CHANGE;
            coin_out_vld  <= 1'b1;
            coin_out_type <= greedy_pick(vend_change);
          end else begin
            state <= S_DONE;
          end
        end

        S_CHANGE: begin
          change_rem <= rem_next;
          if (rem_next == '0) begin
            coin_out_vld  <= 1'b0;
            coin_out_type <= '0;
            if (refund) begin
              state     <= S_IDLE;
              collected <= '0;
              refund    <= 1'b0;
            end else begin
              state <= S_DONE;
            end
          end else begin
            coin_out_type <= greedy_pick(rem_next);
          end
        end

        S_DONE: begin
          if (cont) begin
            state      <= S_IDLE;
            collected  <= '0;
            change_rem <= '0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
